// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg: format codes, instruction width, range limits and stage types
// shared by the immediate encoder slice.
`default_nettype none

package imm_encoder_pkg;

   localparam int INSTR_WIDTH = 32;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_e;

   localparam logic signed [31:0] I_MIN = -32'sd2048;
   localparam logic signed [31:0] I_MAX =  32'sd2047;
   localparam logic signed [31:0] B_MIN = -32'sd4096;
   localparam logic signed [31:0] B_MAX =  32'sd4094;
   localparam logic signed [31:0] J_MIN = -32'sd1048576;
   localparam logic signed [31:0] J_MAX =  32'sd1048574;

   typedef struct packed {
      logic [31:0]            imm;
      logic [2:0]             src;
      logic [INSTR_WIDTH-1:0] base;
   } s1_t;

   function automatic logic out_of_range(input logic signed [31:0] v,
                                         input logic signed [31:0] lo,
                                         input logic signed [31:0] hi);
      return (v < lo) || (v > hi);
   endfunction

endpackage

`default_nettype wire

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: input/output beat handshake bundle; master is the loader side,
// slave is the encoder.
`default_nettype none

interface imm_encoder_if;
   import imm_encoder_pkg::*;

   logic                   in_valid;
   logic                   in_ready;
   logic [2:0]             in_imm_src;
   logic [31:0]            in_imm;
   logic [INSTR_WIDTH-1:0] in_base;
   logic                   out_valid;
   logic                   out_ready;
   logic [INSTR_WIDTH-1:0] out_instr;
   logic                   out_err;
   logic [31:0]            out_addr;

   modport master (
      output in_valid, in_imm_src, in_imm, in_base, out_ready,
      input  in_ready, out_valid, out_instr, out_err, out_addr
   );

   modport slave (
      input  in_valid, in_imm_src, in_imm, in_base, out_ready,
      output in_ready, out_valid, out_instr, out_err, out_addr
   );

endinterface

`default_nettype wire

// File: rtl/imm_pack.sv
// imm_pack: scatters an immediate into the RV32I field layout of the selected
// format and flags values that the format cannot represent.
`default_nettype none

module imm_pack
   import imm_encoder_pkg::*;
(
   input  logic signed [31:0]      imm_i,
   input  logic [2:0]              src_i,
   input  logic [INSTR_WIDTH-1:0]  base_i,
   output logic [INSTR_WIDTH-1:0]  instr_o,
   output logic                    err_o
);

   always_comb begin
      instr_o = base_i;
      err_o   = 1'b0;
      case (src_i)
         IMM_I: begin
            instr_o[31:20] = imm_i[11:0];
            err_o          = out_of_range(imm_i, I_MIN, I_MAX);
         end
         IMM_S: begin
            instr_o[31:25] = imm_i[11:5];
            instr_o[11:7]  = imm_i[4:0];
            err_o          = out_of_range(imm_i, I_MIN, I_MAX);
         end
         IMM_B: begin
            instr_o[31]    = imm_i[12];
            instr_o[30:25] = imm_i[10:5];
            instr_o[11:8]  = imm_i[4:1];
            instr_o[7]     = imm_i[11];
            err_o          = out_of_range(imm_i, B_MIN, B_MAX) || imm_i[0];
         end
         IMM_J: begin
            instr_o[31]    = imm_i[20];
            instr_o[30:21] = imm_i[10:1];
            instr_o[20]    = imm_i[11];
            instr_o[19:12] = imm_i[19:12];
            err_o          = out_of_range(imm_i, J_MIN, J_MAX) || imm_i[0];
         end
         IMM_U: begin
            instr_o[31:12] = imm_i[31:12];
            err_o          = (imm_i[11:0] != 12'd0);
         end
         // Unknown format: word passes through untouched but is marked bad.
         default: err_o = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready immediate encoder with a running word
// address and a saturating count of erroneous beats delivered.
`default_nettype none

module imm_encoder
   import imm_encoder_pkg::*;
#(
   parameter int          ERR_CNT_W = 8,
   parameter logic [31:0] ADDR_RST  = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 flush,
   imm_encoder_if.slave         bus,
   output logic [ERR_CNT_W-1:0] err_count
);

   logic                   s1_v_q, s1_v_d;
   s1_t                    s1_q, s1_d;
   logic                   s2_v_q, s2_v_d;
   logic [INSTR_WIDTH-1:0] s2_instr_q, s2_instr_d;
   logic                   s2_err_q, s2_err_d;
   logic [31:0]            addr_q, addr_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

   logic [INSTR_WIDTH-1:0] pack_instr;
   logic                   pack_err;
   logic                   s2_adv, s1_adv, out_fire;

   imm_pack u_pack (
      .imm_i   (s1_q.imm),
      .src_i   (s1_q.src),
      .base_i  (s1_q.base),
      .instr_o (pack_instr),
      .err_o   (pack_err)
   );

   // A stage may load when the stage after it is empty or draining this cycle.
   assign s2_adv   = !s2_v_q || bus.out_ready;
   assign s1_adv   = !s1_v_q || s2_adv;
   assign out_fire = s2_v_q && bus.out_ready;

   always_comb begin
      s1_v_d     = s1_v_q;
      s1_d       = s1_q;
      s2_v_d     = s2_v_q;
      s2_instr_d = s2_instr_q;
      s2_err_d   = s2_err_q;
      addr_d     = addr_q;
      err_cnt_d  = err_cnt_q;

      if (s2_adv) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            s2_instr_d = pack_instr;
            s2_err_d   = pack_err;
         end
      end
      if (s1_adv) begin
         s1_v_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_d = '{imm: bus.in_imm, src: bus.in_imm_src, base: bus.in_base};
         end
      end
      if (out_fire) begin
         addr_d = addr_q + 32'd4;
         if (s2_err_q && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + 1'b1;
         end
      end
      // Flush drops every beat in flight, including any handshake this cycle.
      if (flush) begin
         s1_v_d    = 1'b0;
         s2_v_d    = 1'b0;
         addr_d    = addr_q;
         err_cnt_d = err_cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1_v_q     <= 1'b0;
         s1_q       <= '0;
         s2_v_q     <= 1'b0;
         s2_instr_q <= '0;
         s2_err_q   <= 1'b0;
         addr_q     <= ADDR_RST;
         err_cnt_q  <= '0;
      end else begin
         s1_v_q     <= s1_v_d;
         s1_q       <= s1_d;
         s2_v_q     <= s2_v_d;
         s2_instr_q <= s2_instr_d;
         s2_err_q   <= s2_err_d;
         addr_q     <= addr_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign bus.in_ready  = s1_adv;
   assign bus.out_valid = s2_v_q;
   assign bus.out_instr = s2_instr_q;
   assign bus.out_err   = s2_err_q;
   assign bus.out_addr  = addr_q;
   assign err_count     = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed vectors for imm_encoder covering formats, errors,
// backpressure, flush, reset and error-counter saturation.
`default_nettype none

module tb_imm_encoder;
   import imm_encoder_pkg::*;

   logic       clk   = 1'b0;
   logic       rstn  = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] err_count;

   imm_encoder_if bus ();

   imm_encoder #(
      .ERR_CNT_W (8),
      .ADDR_RST  (32'h0000_0000)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .bus       (bus),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   int          n_vec    = 0;
   int          n_miss   = 0;
   logic [31:0] exp_addr = 32'h0;
   logic [7:0]  exp_errs = 8'd0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_beat(input logic [2:0] src, input logic [31:0] imm,
                             input logic [31:0] base);
      bus.in_valid   = 1'b1;
      bus.in_imm_src = src;
      bus.in_imm     = imm;
      bus.in_base    = base;
      step();
      bus.in_valid   = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rstn          = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_imm_src = 3'b001;
      bus.in_imm    = 32'h5;
      bus.in_base   = 32'hFFFF_FFFF;
      bus.out_ready = 1'b1;
      repeat (3) step();
      rstn         = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("FAIL rst_valid: got %b expected 0", bus.out_valid); end
      n_vec++; if (bus.out_instr !== 32'h0) begin n_miss++; $display("FAIL rst_instr: got %h expected 00000000", bus.out_instr); end
      n_vec++; if (bus.out_err !== 1'b0) begin n_miss++; $display("FAIL rst_err: got %b expected 0", bus.out_err); end
      n_vec++; if (bus.out_addr !== 32'h0) begin n_miss++; $display("FAIL rst_addr: got %h expected 00000000", bus.out_addr); end
      n_vec++; if (err_count !== 8'd0) begin n_miss++; $display("FAIL rst_errcnt: got %0d expected 0", err_count); end
      n_vec++; if (bus.in_ready !== 1'b1) begin n_miss++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
   endtask

   task automatic test_formats();
      logic [2:0]  src [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
      logic [31:0] imm [5] = '{32'h123, 32'h123, 32'h100, 32'h1000, 32'h0020_0000};
      logic [31:0] base[5] = '{32'h93, 32'h0020_2023, 32'h63, 32'h6F, 32'h137};
      logic [31:0] exp [5] = '{32'h1230_0093, 32'h1220_21A3, 32'h1000_0063, 32'h0000_106F, 32'h0020_0137};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive_beat(src[i], imm[i], base[i]);
         n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("FAIL fmt%0d_early: out_valid got %b expected 0", i, bus.out_valid); end
         step();
         n_vec++; if (bus.out_valid !== 1'b1) begin n_miss++; $display("FAIL fmt%0d_lat: out_valid got %b expected 1", i, bus.out_valid); end
         n_vec++; if (bus.out_instr !== exp[i]) begin n_miss++; $display("FAIL fmt%0d_instr: got %h expected %h", i, bus.out_instr, exp[i]); end
         n_vec++; if (bus.out_err !== 1'b0) begin n_miss++; $display("FAIL fmt%0d_err: got %b expected 0", i, bus.out_err); end
         n_vec++; if (bus.out_addr !== exp_addr) begin n_miss++; $display("FAIL fmt%0d_addr: got %h expected %h", i, bus.out_addr, exp_addr); end
         step();
         exp_addr += 32'd4;
      end
   endtask

   task automatic test_errors();
      logic [2:0]  src [5] = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b101};
      logic [31:0] imm [5] = '{32'hFFFF_FF00, 32'h800, 32'h101, 32'h123, 32'h55};
      logic [31:0] base[5] = '{32'h93, 32'h93, 32'h63, 32'h137, 32'h1234_5678};
      logic [31:0] exp [5] = '{32'hF000_0093, 32'h8000_0093, 32'h1000_0063, 32'h0000_0137, 32'h1234_5678};
      logic        eerr[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive_beat(src[i], imm[i], base[i]);
         step();
         n_vec++; if (bus.out_instr !== exp[i]) begin n_miss++; $display("FAIL err%0d_instr: got %h expected %h", i, bus.out_instr, exp[i]); end
         n_vec++; if (bus.out_err !== eerr[i]) begin n_miss++; $display("FAIL err%0d_flag: got %b expected %b", i, bus.out_err, eerr[i]); end
         n_vec++; if (bus.out_addr !== exp_addr) begin n_miss++; $display("FAIL err%0d_addr: got %h expected %h", i, bus.out_addr, exp_addr); end
         step();
         exp_addr += 32'd4;
         if (eerr[i]) exp_errs++;
      end
      n_vec++; if (err_count !== 8'd4) begin n_miss++; $display("FAIL err_count: got %0d expected 4", err_count); end
   endtask

   task automatic test_backpressure();
      int          sent = 0;
      int          got  = 0;
      int          occ  = 0;
      logic        hold_v = 1'b0;
      logic [31:0] hold_instr = 32'h0;
      logic [31:0] hold_addr  = 32'h0;
      logic        exp_rdy;
      logic [31:0] exp_instr;
      for (int c = 0; c < 40 && got < 6; c++) begin
         bus.out_ready  = !(c >= 2 && c < 5);
         bus.in_valid   = (sent < 6);
         bus.in_imm_src = IMM_I;
         bus.in_imm     = 32'(sent);
         bus.in_base    = 32'h13;
         #1;
         exp_rdy = !(occ == 2 && !bus.out_ready);
         n_vec++; if (bus.in_ready !== exp_rdy) begin n_miss++; $display("FAIL bp_in_ready c%0d: got %b expected %b", c, bus.in_ready, exp_rdy); end
         if (hold_v) begin
            n_vec++; if (bus.out_valid !== 1'b1 || bus.out_instr !== hold_instr || bus.out_addr !== hold_addr) begin
               n_miss++; $display("FAIL bp_stable c%0d: got v=%b %h @%h expected v=1 %h @%h", c, bus.out_valid, bus.out_instr, bus.out_addr, hold_instr, hold_addr);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            exp_instr = (32'(got) << 20) | 32'h13;
            n_vec++; if (bus.out_instr !== exp_instr || bus.out_addr !== exp_addr) begin
               n_miss++; $display("FAIL bp_beat%0d: got %h @%h expected %h @%h", got, bus.out_instr, bus.out_addr, exp_instr, exp_addr);
            end
            got++;
            occ--;
            exp_addr += 32'd4;
         end
         hold_v     = bus.out_valid && !bus.out_ready;
         hold_instr = bus.out_instr;
         hold_addr  = bus.out_addr;
         if (bus.in_valid && bus.in_ready) begin
            sent++;
            occ++;
         end
         step();
      end
      bus.in_valid = 1'b0;
      n_vec++; if (got != 6) begin n_miss++; $display("FAIL bp_count: got %0d beats expected 6", got); end
   endtask

   task automatic test_flush_reset();
      bus.out_ready = 1'b0;
      drive_beat(IMM_I, 32'h1, 32'h13);
      drive_beat(IMM_I, 32'h2, 32'h13);
      n_vec++; if (bus.out_valid !== 1'b1) begin n_miss++; $display("FAIL fl_pre_valid: got %b expected 1", bus.out_valid); end
      flush         = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      step();
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("FAIL fl_valid: got %b expected 0", bus.out_valid); end
      n_vec++; if (bus.out_addr !== exp_addr) begin n_miss++; $display("FAIL fl_addr: got %h expected %h", bus.out_addr, exp_addr); end
      n_vec++; if (err_count !== exp_errs) begin n_miss++; $display("FAIL fl_errcnt: got %0d expected %0d", err_count, exp_errs); end
      step();
      n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("FAIL fl_discard: got %b expected 0", bus.out_valid); end

      drive_beat(3'b101, 32'h0, 32'hABCD_0000);
      drive_beat(IMM_I, 32'h3, 32'h13);
      n_vec++; if (bus.out_err !== 1'b1) begin n_miss++; $display("FAIL rs_pre_err: got %b expected 1", bus.out_err); end
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      #1;
      exp_addr = 32'h0;
      exp_errs = 8'd0;
      n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("FAIL rs_valid: got %b expected 0", bus.out_valid); end
      n_vec++; if (bus.out_instr !== 32'h0) begin n_miss++; $display("FAIL rs_instr: got %h expected 00000000", bus.out_instr); end
      n_vec++; if (bus.out_err !== 1'b0) begin n_miss++; $display("FAIL rs_err: got %b expected 0", bus.out_err); end
      n_vec++; if (bus.out_addr !== 32'h0) begin n_miss++; $display("FAIL rs_addr: got %h expected 00000000", bus.out_addr); end
      n_vec++; if (err_count !== 8'd0) begin n_miss++; $display("FAIL rs_errcnt: got %0d expected 0", err_count); end
      step();
      n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("FAIL rs_discard: got %b expected 0", bus.out_valid); end
   endtask

   task automatic test_saturation();
      int         sent = 0;
      int         got  = 0;
      logic [7:0] exp_cnt;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 400 && got < 260; c++) begin
         bus.in_valid   = (sent < 260);
         bus.in_imm_src = 3'b101;
         bus.in_imm     = 32'h0;
         bus.in_base    = 32'(c);
         #1;
         exp_cnt = (got > 255) ? 8'd255 : 8'(got);
         n_vec++; if (err_count !== exp_cnt) begin n_miss++; $display("FAIL sat_cnt c%0d: got %0d expected %0d", c, err_count, exp_cnt); end
         if (bus.out_valid && bus.out_ready) got++;
         if (bus.in_valid && bus.in_ready) sent++;
         step();
      end
      bus.in_valid = 1'b0;
      n_vec++; if (got != 260) begin n_miss++; $display("FAIL sat_beats: got %0d expected 260", got); end
      n_vec++; if (err_count !== 8'd255) begin n_miss++; $display("FAIL sat_final: got %0d expected 255", err_count); end
      n_vec++; if (bus.out_addr !== 32'd1040) begin n_miss++; $display("FAIL sat_addr: got %h expected %h", bus.out_addr, 32'd1040); end
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_imm_src = 3'b000;
      bus.in_imm     = 32'h0;
      bus.in_base    = 32'h0;
      bus.out_ready  = 1'b0;
      test_reset();
      test_formats();
      test_errors();
      test_backpressure();
      test_flush_reset();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
